// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_pkg
// Purpose  : Shared types and helpers for the memory-stage access unit.
//            mem_op_t     - load/store operation encoding from EX/MEM
//            mas_state_t  - access FSM state encoding
//            is_load()    - true for LW/LH/LHU/LB/LBU
//            misaligned() - true when the byte offset violates op alignment
// Revision : 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

    typedef enum logic [2:0] {
        LW  = 3'd0,
        LH  = 3'd1,
        LHU = 3'd2,
        LB  = 3'd3,
        LBU = 3'd4,
        SW  = 3'd5,
        SH  = 3'd6,
        SB  = 3'd7
    } mem_op_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD_WAIT = 2'd1,
        RMW_MERGE = 2'd2
    } mas_state_t;

    function automatic logic is_load(input mem_op_t op);
        return (op == LW) || (op == LH) || (op == LHU) ||
               (op == LB) || (op == LBU);
    endfunction

    // Words need offset 0, halfwords an even offset; bytes never fault.
    function automatic logic misaligned(input mem_op_t op, input logic [1:0] off);
        logic r;
        case (op)
            LW, SW:      r = (off != 2'd0);
            LH, LHU, SH: r = off[0];
            default:     r = 1'b0;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// ============================================================================
// Module   : load_align
// Purpose  : Combinational load lane select and extension (big-endian).
//            Offset 0 selects bits [31:24]; halfword offset 0 selects [31:16].
// Ports    : i_word  [31:0] - word read from data memory
//            i_off   [1:0]  - byte offset within the word
//            i_op    mem_op_t - load operation (LW/LH/LHU/LB/LBU)
//            o_data  [31:0] - extended load value
// Revision : 1.0 - initial release
// ============================================================================
module load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_off,
    input  mem_op_t     i_op,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = 8'h00;
        case (i_off)
            2'd0:    w_byte = i_word[31:24];
            2'd1:    w_byte = i_word[23:16];
            2'd2:    w_byte = i_word[15:8];
            default: w_byte = i_word[7:0];
        endcase
        // Only the even offsets reach here for halfword loads.
        w_half = i_off[1] ? i_word[15:0] : i_word[31:16];
    end

    always_comb begin
        o_data = i_word;
        case (i_op)
            LB:      o_data = {{24{w_byte[7]}}, w_byte};
            LBU:     o_data = {24'h000000, w_byte};
            LH:      o_data = {{16{w_half[15]}}, w_half};
            LHU:     o_data = {16'h0000, w_half};
            default: o_data = i_word;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : Memory-stage access controller between the EX/MEM register and
//            a word-wide data memory with 1-cycle synchronous read/write.
//            Word stores write directly; byte/half stores do read-modify-
//            write; loads are lane-selected and extended. Misaligned
//            requests raise a one-cycle ALIGN_ERR and touch nothing.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            REQ_VALID/READY   - request handshake (READY = state is IDLE)
//            MEM_OP [2:0]      - mem_op_t operation
//            BYTE_ADDR         - byte address (ADDR_WIDTH+2 bits)
//            STORE_DATA        - store value (SB uses [7:0], SH [15:0])
//            RSP_VALID         - one-cycle pulse, LOAD_DATA holds a new load
//            LOAD_DATA         - registered extended load result
//            ALIGN_ERR         - one-cycle pulse after a misaligned accept
//            DM_W_EN/ADDR/WDATA- data memory write enable, word addr, data
//            DM_RDATA          - data memory read data (1 cycle after addr)
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit
    import mem_stage_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  REQ_VALID,
    output logic                  REQ_READY,
    input  logic [2:0]            MEM_OP,
    input  logic [ADDR_WIDTH+1:0] BYTE_ADDR,
    input  logic [DATA_WIDTH-1:0] STORE_DATA,
    output logic                  RSP_VALID,
    output logic [DATA_WIDTH-1:0] LOAD_DATA,
    output logic                  ALIGN_ERR,
    output logic                  DM_W_EN,
    output logic [ADDR_WIDTH-1:0] DM_ADDR,
    output logic [DATA_WIDTH-1:0] DM_WDATA,
    input  logic [DATA_WIDTH-1:0] DM_RDATA
);

    mas_state_t            r_state;
    mem_op_t               r_op;
    logic [1:0]            r_off;
    logic [15:0]           r_sdata;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic                  r_rsp_valid;
    logic                  r_align_err;
    logic [DATA_WIDTH-1:0] r_load_data;

    mem_op_t               w_op;
    logic                  w_ready;
    logic                  w_accept;
    logic                  w_misal;
    logic [1:0]            w_off;
    logic [DATA_WIDTH-1:0] w_load_val;
    logic [DATA_WIDTH-1:0] w_merge;
    logic                  w_dm_we;
    logic [ADDR_WIDTH-1:0] w_dm_addr;
    logic [DATA_WIDTH-1:0] w_dm_wdata;

    assign w_op     = mem_op_t'(MEM_OP);
    assign w_off    = BYTE_ADDR[1:0];
    assign w_ready  = (r_state == IDLE);
    assign w_accept = REQ_VALID & w_ready;
    assign w_misal  = misaligned(w_op, w_off);

    // ------------------------------------------------------------------
    // Load extraction from the word returned during LOAD_WAIT
    // ------------------------------------------------------------------
    load_align u_load_align (
        .i_word (DM_RDATA),
        .i_off  (r_off),
        .i_op   (r_op),
        .o_data (w_load_val)
    );

    // ------------------------------------------------------------------
    // Sub-word store merge: replace the target lane of the word read back
    // during RMW_MERGE, keeping the other lanes intact.
    // ------------------------------------------------------------------
    always_comb begin
        w_merge = DM_RDATA;
        if (r_op == SB) begin
            case (r_off)
                2'd0:    w_merge[31:24] = r_sdata[7:0];
                2'd1:    w_merge[23:16] = r_sdata[7:0];
                2'd2:    w_merge[15:8]  = r_sdata[7:0];
                default: w_merge[7:0]   = r_sdata[7:0];
            endcase
        end else begin
            if (r_off[1]) begin
                w_merge[15:0]  = r_sdata;
            end else begin
                w_merge[31:16] = r_sdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Memory port drive. Writes are gated by rst so that a store presented
    // during reset, or an RMW in flight when reset hits, never lands.
    // ------------------------------------------------------------------
    always_comb begin
        w_dm_we    = 1'b0;
        w_dm_addr  = r_waddr;
        w_dm_wdata = w_merge;
        case (r_state)
            IDLE: begin
                // Address goes out in the accept cycle so read data is back
                // in the following cycle for both loads and RMW.
                w_dm_addr  = BYTE_ADDR[ADDR_WIDTH+1:2];
                w_dm_wdata = STORE_DATA;
                if (!rst && w_accept && !w_misal && (w_op == SW)) begin
                    w_dm_we = 1'b1;
                end
            end
            RMW_MERGE: begin
                w_dm_we = !rst;
            end
            default: begin
                w_dm_we = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Access FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_op        <= LW;
            r_off       <= 2'd0;
            r_sdata     <= 16'h0000;
            r_waddr     <= '0;
            r_rsp_valid <= 1'b0;
            r_align_err <= 1'b0;
            r_load_data <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_align_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_misal) begin
                            r_align_err <= 1'b1;
                        end else begin
                            r_op    <= w_op;
                            r_off   <= w_off;
                            r_sdata <= STORE_DATA[15:0];
                            r_waddr <= BYTE_ADDR[ADDR_WIDTH+1:2];
                            if (is_load(w_op)) begin
                                r_state <= LOAD_WAIT;
                            end else if (w_op != SW) begin
                                r_state <= RMW_MERGE;
                            end
                        end
                    end
                end
                LOAD_WAIT: begin
                    r_load_data <= w_load_val;
                    r_rsp_valid <= 1'b1;
                    r_state     <= IDLE;
                end
                RMW_MERGE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign REQ_READY = w_ready;
    assign RSP_VALID = r_rsp_valid;
    assign LOAD_DATA = r_load_data;
    assign ALIGN_ERR = r_align_err;
    assign DM_W_EN   = w_dm_we;
    assign DM_ADDR   = w_dm_addr;
    assign DM_WDATA  = w_dm_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Purpose  : Scoreboard bench for mem_access_unit with a behavioural
//            1-cycle synchronous data memory and a backdoor preload port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;
    import mem_stage_pkg::*;

    localparam int K_LOAD = 0;
    localparam int K_SW   = 1;
    localparam int K_RMW  = 2;
    localparam int K_ERR  = 3;
    localparam int K_NONE = 4;

    logic        clk;
    logic        rst;
    logic        REQ_VALID;
    logic        REQ_READY;
    logic [2:0]  MEM_OP;
    logic [11:0] BYTE_ADDR;
    logic [31:0] STORE_DATA;
    logic        RSP_VALID;
    logic [31:0] LOAD_DATA;
    logic        ALIGN_ERR;
    logic        DM_W_EN;
    logic [9:0]  DM_ADDR;
    logic [31:0] DM_WDATA;
    logic [31:0] DM_RDATA;

    logic        bd_we;
    logic [9:0]  bd_addr;
    logic [31:0] bd_data;
    logic [31:0] mem [0:1023];

    typedef struct {
        int          cyc;
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } ld_t;

    wr_t wq[$];
    ld_t lq[$];
    int  eq[$];

    int nt = 0;
    int nf = 0;
    int cyc_n = 0;

    mem_access_unit #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .REQ_VALID  (REQ_VALID),
        .REQ_READY  (REQ_READY),
        .MEM_OP     (MEM_OP),
        .BYTE_ADDR  (BYTE_ADDR),
        .STORE_DATA (STORE_DATA),
        .RSP_VALID  (RSP_VALID),
        .LOAD_DATA  (LOAD_DATA),
        .ALIGN_ERR  (ALIGN_ERR),
        .DM_W_EN    (DM_W_EN),
        .DM_ADDR    (DM_ADDR),
        .DM_WDATA   (DM_WDATA),
        .DM_RDATA   (DM_RDATA)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: read returns the pre-write contents of the addressed word.
    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (DM_W_EN) mem[DM_ADDR] <= DM_WDATA;
        DM_RDATA <= mem[DM_ADDR];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nt++;
        if (act !== exp) begin
            nf++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an event.
    always @(negedge clk) begin
        wr_t w;
        ld_t l;
        int  e;
        cyc_n++;
        if (DM_W_EN === 1'b1) begin
            if (wq.size() == 0) begin
                nt++; nf++;
                $display("FAIL unexpected_write: got addr %h data %h at cycle %0d expected none",
                         DM_ADDR, DM_WDATA, cyc_n);
            end else begin
                w = wq.pop_front();
                check("write_cycle", 32'(cyc_n), 32'(w.cyc));
                check("write_addr", {22'd0, DM_ADDR}, {22'd0, w.addr});
                check("write_data", DM_WDATA, w.data);
            end
        end
        if (RSP_VALID === 1'b1) begin
            if (lq.size() == 0) begin
                nt++; nf++;
                $display("FAIL unexpected_rsp: got data %h at cycle %0d expected none", LOAD_DATA, cyc_n);
            end else begin
                l = lq.pop_front();
                check("rsp_cycle", 32'(cyc_n), 32'(l.cyc));
                check("load_data", LOAD_DATA, l.data);
            end
        end
        if (ALIGN_ERR === 1'b1) begin
            if (eq.size() == 0) begin
                nt++; nf++;
                $display("FAIL unexpected_align_err: got pulse at cycle %0d expected none", cyc_n);
            end else begin
                e = eq.pop_front();
                check("align_err_cycle", 32'(cyc_n), 32'(e));
            end
        end
    end

    task automatic poke(input logic [9:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        REQ_VALID = 1'b0;
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        @(posedge clk); #1;
        bd_we = 1'b0;
    endtask

    // Presents a request, waits (bounded) for acceptance and records the
    // expected response. Returns in the accept cycle with REQ_VALID still 1.
    task automatic issue(input mem_op_t op, input logic [11:0] addr, input logic [31:0] sd,
                         input int kind, input logic [31:0] expv);
        int  n;
        int  acc;
        wr_t w;
        ld_t l;
        n = 0;
        @(posedge clk); #1;
        REQ_VALID = 1'b1; MEM_OP = op; BYTE_ADDR = addr; STORE_DATA = sd;
        while (!REQ_READY && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        if (!REQ_READY) begin
            nt++; nf++;
            $display("FAIL issue_timeout: got REQ_READY 0 expected 1 within 8 cycles");
            REQ_VALID = 1'b0;
            return;
        end
        acc = cyc_n + 1;
        case (kind)
            K_LOAD: begin l.cyc = acc + 2; l.data = expv; lq.push_back(l); end
            K_SW:   begin w.cyc = acc; w.addr = addr[11:2]; w.data = expv; wq.push_back(w); end
            K_RMW:  begin w.cyc = acc + 1; w.addr = addr[11:2]; w.data = expv; wq.push_back(w); end
            K_ERR:  eq.push_back(acc + 1);
            default: ;
        endcase
    endtask

    task automatic idle(input int n);
        @(posedge clk); #1;
        REQ_VALID = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        REQ_VALID = 1'b1; MEM_OP = SW; BYTE_ADDR = 12'h010; STORE_DATA = 32'h12345678;
        bd_we = 1'b0; bd_addr = '0; bd_data = '0;

        // Reset with a word store pending
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check("rst_dm_w_en", {31'd0, DM_W_EN}, 32'd0);
        check("rst_rsp_valid", {31'd0, RSP_VALID}, 32'd0);
        check("rst_align_err", {31'd0, ALIGN_ERR}, 32'd0);
        check("rst_load_data", LOAD_DATA, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0; REQ_VALID = 1'b0;
        check("rst_req_ready", {31'd0, REQ_READY}, 32'd1);

        // Word store followed immediately by word load of the same address
        issue(SW, 12'h010, 32'hDEADBEEF, K_SW,   32'hDEADBEEF);
        issue(LW, 12'h010, 32'h0,        K_LOAD, 32'hDEADBEEF);
        idle(3);

        // Extension and lane selection
        poke(10'h008, 32'h80FF7F01);
        issue(LB,  12'h020, 32'h0, K_LOAD, 32'hFFFFFF80);
        issue(LBU, 12'h020, 32'h0, K_LOAD, 32'h00000080);
        issue(LH,  12'h022, 32'h0, K_LOAD, 32'h00007F01);
        issue(LH,  12'h020, 32'h0, K_LOAD, 32'hFFFF80FF);
        issue(LHU, 12'h020, 32'h0, K_LOAD, 32'h000080FF);
        issue(LB,  12'h021, 32'h0, K_LOAD, 32'hFFFFFFFF);
        issue(LBU, 12'h022, 32'h0, K_LOAD, 32'h0000007F);
        issue(LB,  12'h023, 32'h0, K_LOAD, 32'h00000001);
        idle(3);

        // Sub-word read-modify-write, REQ_READY drops for the merge cycle
        poke(10'h00C, 32'h11223344);
        issue(SB, 12'h031, 32'h123456AA, K_RMW, 32'h11AA3344);
        @(posedge clk); #1;
        REQ_VALID = 1'b0;
        check("rmw_ready_low", {31'd0, REQ_READY}, 32'd0);
        @(posedge clk); #1;
        check("rmw_ready_back", {31'd0, REQ_READY}, 32'd1);
        issue(SH, 12'h032, 32'hFFFFBEEF, K_RMW,  32'h11AABEEF);
        issue(LW, 12'h030, 32'h0,        K_LOAD, 32'h11AABEEF);
        issue(SB, 12'h030, 32'h00000077, K_RMW,  32'h77AABEEF);
        issue(SH, 12'h030, 32'h00001234, K_RMW,  32'h1234BEEF);
        idle(3);

        // Misaligned requests
        poke(10'h010, 32'hCAFEF00D);
        issue(LW,  12'h041, 32'h0,        K_ERR, 32'h0);
        issue(SH,  12'h043, 32'h00005555, K_ERR, 32'h0);
        issue(SW,  12'h042, 32'h01020304, K_ERR, 32'h0);
        issue(LHU, 12'h041, 32'h0,        K_ERR, 32'h0);
        issue(LB,  12'h041, 32'h0,        K_LOAD, 32'hFFFFFFFE);
        idle(3);
        check("misalign_mem_kept", mem[16], 32'hCAFEF00D);
        check("load_data_held", LOAD_DATA, 32'hFFFFFFFE);

        // Reset during RMW_MERGE: write suppressed
        poke(10'h014, 32'h55667788);
        issue(SB, 12'h050, 32'h00000099, K_NONE, 32'h0);
        @(posedge clk); #1;
        REQ_VALID = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);
        check("rst_rmw_mem_kept", mem[20], 32'h55667788);

        // Reset during LOAD_WAIT: response dropped
        issue(LW, 12'h050, 32'h0, K_NONE, 32'h0);
        @(posedge clk); #1;
        REQ_VALID = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        idle(3);

        // Loads after reset, including the top word of memory
        poke(10'h0FF, 32'h123456F0);
        poke(10'h3FF, 32'hA500007E);
        issue(LB,  12'h3FF, 32'h0, K_LOAD, 32'hFFFFFFF0);
        issue(LB,  12'hFFF, 32'h0, K_LOAD, 32'h0000007E);
        issue(LH,  12'hFFC, 32'h0, K_LOAD, 32'hFFFFA500);
        issue(SB,  12'hFFE, 32'h000000C3, K_RMW, 32'hA500C37E);
        issue(LW,  12'hFFC, 32'h0, K_LOAD, 32'hA500C37E);
        idle(4);

        check("end_mem_word4", mem[4], 32'hDEADBEEF);
        check("end_mem_word12", mem[12], 32'h1234BEEF);
        check("end_write_queue", 32'(wq.size()), 32'd0);
        check("end_load_queue", 32'(lq.size()), 32'd0);
        check("end_err_queue", 32'(eq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", nt, nf);
        $finish;
    end

endmodule
`default_nettype wire
